// File: rtl/mem_stage.sv
// Memory stage: 32x32 data RAM, load/store handling and the writeback register.
// Optional macro DMEM_FAST_LOAD_EN selects an asynchronous-read RAM with single-cycle loads.
`timescale 1ns/1ps

module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [31:0] alu_res,
    input  logic [31:0] write_data,
    input  logic [4:0]  rd_addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
    input  logic        flush,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic [31:0] fwd_res
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] LOAD_WAIT = 1'b1;

    logic [31:0] ram [0:31];
    logic [0:0]  state;
    logic [4:0]  addr;
    logic        accept;
    logic        is_store;
    logic        is_load;

    assign addr     = alu_res[4:0];
    assign is_store = mem_write;
    // A combined read+write is treated as a store.
    assign is_load  = mem_read & ~mem_write;
    assign stall    = (state == LOAD_WAIT);
    assign accept   = in_valid & ~stall & ~flush;
    assign fwd_res  = wb_data;

    // RAM is never cleared; reset only blocks a write on the reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && accept && is_store) begin
            ram[addr] <= write_data;
        end
    end

`ifndef DMEM_FAST_LOAD_EN
    logic [4:0] ld_addr_p1;
    logic [4:0] ld_rd_p1;
    logic       ld_rw_p1;

    always_ff @(posedge clk) begin
        if (accept && is_load) begin
            ld_addr_p1 <= addr;
            ld_rd_p1   <= rd_addr;
            ld_rw_p1   <= reg_write;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_data      <= 32'd0;
            wb_rd        <= 5'd0;
`ifndef DMEM_FAST_LOAD_EN
        end else if (state == LOAD_WAIT) begin
            // Synchronous RAM read lands directly in the writeback register.
            state <= IDLE;
            if (flush) begin
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end else begin
                wb_valid     <= 1'b1;
                wb_data      <= ram[ld_addr_p1];
                wb_rd        <= ld_rd_p1;
                wb_reg_write <= ld_rw_p1;
            end
`endif
        end else if (accept && is_load) begin
`ifdef DMEM_FAST_LOAD_EN
            wb_valid     <= 1'b1;
            wb_data      <= ram[addr];
            wb_rd        <= rd_addr;
            wb_reg_write <= reg_write;
`else
            state        <= LOAD_WAIT;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
`endif
        end else if (accept) begin
            wb_valid     <= 1'b1;
            wb_data      <= alu_res;
            wb_rd        <= rd_addr;
            wb_reg_write <= reg_write & ~is_store;
        end else begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage; follows DMEM_FAST_LOAD_EN for load latency.
`timescale 1ns/1ps

module tb_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] alu_res;
    logic [31:0] write_data;
    logic [4:0]  rd_addr;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] fwd_res;

    int checks = 0;
    int errors = 0;

    mem_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .alu_res(alu_res),
        .write_data(write_data), .rd_addr(rd_addr), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .flush(flush),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write), .fwd_res(fwd_res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] rd, input logic mr, input logic mw, input logic rw);
        in_valid   = v;
        alu_res    = a;
        write_data = d;
        rd_addr    = rd;
        mem_read   = mr;
        mem_write  = mw;
        reg_write  = rw;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, a, d, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        idle();
    endtask

    // Leaves the outputs showing the load completion.
    task automatic issue_load(input logic [31:0] a, input logic [4:0] rd);
        drive(1'b1, a, 32'd0, rd, 1'b1, 1'b0, 1'b1);
        step();
`ifndef DMEM_FAST_LOAD_EN
        idle();
        step();
`endif
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(1'b1, 32'h34, 32'd0, 5'd5, 1'b0, 1'b0, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %h want 0", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rst_wb_reg_write got %h want 0", wb_reg_write); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL rst_wb_data got %h want 0", wb_data); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd got %h want 0", wb_rd); end
        checks++; if (fwd_res !== 32'd0) begin errors++; $display("FAIL rst_fwd_res got %h want 0", fwd_res); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %h want 0", stall); end
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_alu();
        drive(1'b1, 32'h12, 32'hFFFF_0000, 5'd7, 1'b0, 1'b0, 1'b1);
        step();
        idle();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %h want 1", wb_valid); end
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL alu_wb_rd got %h want 07", wb_rd); end
        checks++; if (wb_data !== 32'h12) begin errors++; $display("FAIL alu_wb_data got %h want 00000012", wb_data); end
        checks++; if (fwd_res !== 32'h12) begin errors++; $display("FAIL alu_fwd_res got %h want 00000012", fwd_res); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL alu_wb_reg_write got %h want 1", wb_reg_write); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %h want 0", stall); end
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_wb_valid got %h want 0", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL bubble_wb_reg_write got %h want 0", wb_reg_write); end
        checks++; if (wb_data !== 32'h12) begin errors++; $display("FAIL bubble_wb_data_hold got %h want 00000012", wb_data); end
        checks++; if (wb_rd !== 5'd7) begin errors++; $display("FAIL bubble_wb_rd_hold got %h want 07", wb_rd); end
    endtask

    task automatic test_store_wrap_load();
        drive(1'b1, 32'h25, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, 1'b1);
        step();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL st_wb_valid got %h want 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL st_wb_reg_write got %h want 0", wb_reg_write); end
        checks++; if (wb_data !== 32'h25) begin errors++; $display("FAIL st_wb_data got %h want 00000025", wb_data); end
        drive(1'b1, 32'h05, 32'd0, 5'd9, 1'b1, 1'b0, 1'b1);
        step();
`ifndef DMEM_FAST_LOAD_EN
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_wait_stall got %h want 1", stall); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld_wait_wb_valid got %h want 0", wb_valid); end
        // A store presented while stalled must be ignored.
        drive(1'b1, 32'h05, 32'h1111_1111, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
`endif
        idle();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ld_wb_valid got %h want 1", wb_valid); end
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ld_wrap_data got %h want deadbeef", wb_data); end
        checks++; if (wb_rd !== 5'd9) begin errors++; $display("FAIL ld_wb_rd got %h want 09", wb_rd); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL ld_wb_reg_write got %h want 1", wb_reg_write); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_done_stall got %h want 0", stall); end
    endtask

    task automatic test_read_write_both();
        drive(1'b1, 32'h03, 32'h55, 5'd6, 1'b1, 1'b1, 1'b1);
        step();
        idle();
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rw_wb_reg_write got %h want 0", wb_reg_write); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rw_stall got %h want 0", stall); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rw_wb_valid got %h want 1", wb_valid); end
        issue_load(32'h03, 5'd8);
        checks++; if (wb_data !== 32'h55) begin errors++; $display("FAIL rw_load_data got %h want 00000055", wb_data); end
    endtask

    task automatic test_flush_load();
        drive(1'b1, 32'h03, 32'd0, 5'd10, 1'b1, 1'b0, 1'b1);
        step();
`ifndef DMEM_FAST_LOAD_EN
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_wait_stall got %h want 1", stall); end
`endif
        drive(1'b1, 32'hCD, 32'd0, 5'd2, 1'b0, 1'b0, 1'b1);
        flush = 1'b1;
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fl_wb_valid got %h want 0", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL fl_wb_reg_write got %h want 0", wb_reg_write); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fl_stall got %h want 0", stall); end
        checks++; if (wb_data !== 32'h55) begin errors++; $display("FAIL fl_wb_data_hold got %h want 00000055", wb_data); end
        flush = 1'b0;
        step();
        idle();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL fl_next_wb_valid got %h want 1", wb_valid); end
        checks++; if (wb_data !== 32'hCD) begin errors++; $display("FAIL fl_next_wb_data got %h want 000000cd", wb_data); end
    endtask

    task automatic test_flush_store();
        do_store(32'h07, 32'h1234);
        drive(1'b1, 32'h07, 32'h99, 5'd0, 1'b0, 1'b1, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL fst_wb_valid got %h want 0", wb_valid); end
        issue_load(32'h07, 5'd12);
        checks++; if (wb_data !== 32'h1234) begin errors++; $display("FAIL fst_ram_kept got %h want 00001234", wb_data); end
        checks++; if (wb_rd !== 5'd12) begin errors++; $display("FAIL fst_wb_rd got %h want 0c", wb_rd); end
    endtask

    task automatic test_reset_mid_load();
        drive(1'b1, 32'h25, 32'd0, 5'd11, 1'b1, 1'b0, 1'b1);
        step();
        idle();
        rst_n = 1'b0;
        step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rml_stall got %h want 0", stall); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rml_wb_valid got %h want 0", wb_valid); end
        checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL rml_wb_data got %h want 0", wb_data); end
        rst_n = 1'b1;
        step();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rml_no_completion got %h want 0", wb_valid); end
        issue_load(32'h05, 5'd11);
        checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rml_ram_kept got %h want deadbeef", wb_data); end
    endtask

    task automatic test_back_to_back();
        do_store(32'h01, 32'h1111_1111);
        do_store(32'h02, 32'h2222_2222);
        drive(1'b1, 32'h01, 32'd0, 5'd1, 1'b1, 1'b0, 1'b1);
        step();
`ifndef DMEM_FAST_LOAD_EN
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_l1_stall got %h want 1", stall); end
        step();
`endif
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_l1_done_stall got %h want 0", stall); end
        checks++; if (wb_data !== 32'h1111_1111) begin errors++; $display("FAIL b2b_l1_data got %h want 11111111", wb_data); end
        checks++; if (wb_rd !== 5'd1) begin errors++; $display("FAIL b2b_l1_rd got %h want 01", wb_rd); end
        drive(1'b1, 32'h02, 32'd0, 5'd2, 1'b1, 1'b0, 1'b1);
        step();
`ifndef DMEM_FAST_LOAD_EN
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_l2_wait_valid got %h want 0", wb_valid); end
        step();
`endif
        idle();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_l2_stall got %h want 0", stall); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_l2_valid got %h want 1", wb_valid); end
        checks++; if (wb_data !== 32'h2222_2222) begin errors++; $display("FAIL b2b_l2_data got %h want 22222222", wb_data); end
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        test_reset();
        test_alu();
        test_store_wrap_load();
        test_read_write_both();
        test_flush_load();
        test_flush_store();
        test_reset_mid_load();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
